shift_right_seq: RTL and testbench



---
 rtl/shift_right_seq.sv | 105 ++++++++++
 tb/tb_shift_right_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle logical/arithmetic right shifter for srl/sra/srlv/srav.
// One bit per clock under a start/done handshake; the result is held in y until
// the next operation completes.
// Optional build macro SHIFT_FAST_EN: shift by 4 per clock while count >= 4.
module shift_right_seq #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   count;
    logic             fill;
    logic             accept;

    // New work is taken only from IDLE or DONE; start during SHIFT is dropped.
    assign accept = start && (state == IDLE || state == DONE);

`ifdef SHIFT_FAST_EN
    logic signed [WIDTH:0] ext;
    logic [WIDTH-1:0]      work_sh4;
    logic                  big_step;

    // Prepending the fill bit lets a signed shift replicate it into the top nibble.
    assign ext      = {fill, work};
    assign work_sh4 = WIDTH'(ext >>> 4);
    // Widened compare so the constant 4 fits even when SHW is 2.
    assign big_step = ({1'b0, count} >= (SHW+1)'(4));
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (count == '0) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? SHIFT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift while counting, publish y when count hits zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work  <= '0;
            count <= '0;
            fill  <= 1'b0;
            y     <= '0;
        end else if (accept) begin
            work  <= a;
            count <= shamt;
            fill  <= arith & a[WIDTH-1];
        end else if (state == SHIFT) begin
            if (count == '0) begin
                y <= work;
            end else begin
`ifdef SHIFT_FAST_EN
                if (big_step) begin
                    work  <= work_sh4;
                    count <= count - SHW'(4);
                end else begin
                    work  <= {fill, work[WIDTH-1:1]};
                    count <= count - 1'b1;
                end
`else
                work  <= {fill, work[WIDTH-1:1]};
                count <= count - 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed self-checking bench for shift_right_seq (WIDTH = 32).
module tb_shift_right_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] y;

    int checks = 0;
    int errors = 0;

    shift_right_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .shamt (shamt),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived latency (cycles from accepting edge to the done cycle).
    function automatic int exp_lat(input int s);
`ifdef SHIFT_FAST_EN
        return s / 4 + s % 4 + 1;
`else
        return s + 1;
`endif
    endfunction

    // Issue one operation and wait for done. Called at posedge+1; returns in the done cycle
    // (posedge+1). lat = -1 on timeout.
    task automatic run_op(input logic [31:0] a_v, input logic [4:0] s_v, input logic ar_v,
                          output int lat, output int busy_cyc, output int overlap);
        lat = -1; busy_cyc = 0; overlap = 0;
        a = a_v; shamt = s_v; arith = ar_v; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'h0; shamt = 5'd0; arith = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (busy) busy_cyc++;
            if (busy && done) overlap++;
            if (done) begin lat = n; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; a = '0; shamt = '0; arith = 1'b0;
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL reset_y got %h want 00000000", y); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_logical_long();
        int lat, bc, ov;
        run_op(32'h8000_0000, 5'd31, 1'b0, lat, bc, ov);
        checks++; if (y !== 32'h0000_0001) begin errors++; $display("FAIL srl31_y got %h want 00000001", y); end
        checks++; if (lat != exp_lat(31)) begin errors++; $display("FAIL srl31_lat got %0d want %0d", lat, exp_lat(31)); end
        checks++; if (ov != 0) begin errors++; $display("FAIL srl31_busy_done_overlap got %0d want 0", ov); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL srl31_done_width got %0b want 0", done); end
    endtask

    task automatic test_arith();
        int lat, bc, ov;
        run_op(32'h8000_0000, 5'd4, 1'b1, lat, bc, ov);
        checks++; if (y !== 32'hF800_0000) begin errors++; $display("FAIL sra_neg_y got %h want f8000000", y); end
        checks++; if (lat != exp_lat(4)) begin errors++; $display("FAIL sra_neg_lat got %0d want %0d", lat, exp_lat(4)); end
        @(posedge clk); #1;
        run_op(32'h7FFF_FFF0, 5'd4, 1'b1, lat, bc, ov);
        checks++; if (y !== 32'h07FF_FFFF) begin errors++; $display("FAIL sra_pos_y got %h want 07ffffff", y); end
        checks++; if (lat != exp_lat(4)) begin errors++; $display("FAIL sra_pos_lat got %0d want %0d", lat, exp_lat(4)); end
        @(posedge clk); #1;
        // Logical shift of a negative operand must zero-fill.
        run_op(32'hF000_000F, 5'd3, 1'b0, lat, bc, ov);
        checks++; if (y !== 32'h1E00_0001) begin errors++; $display("FAIL srl_negop_y got %h want 1e000001", y); end
        checks++; if (lat != exp_lat(3)) begin errors++; $display("FAIL srl_negop_lat got %0d want %0d", lat, exp_lat(3)); end
        @(posedge clk); #1;
        // Mixed 4-step and 1-step path.
        run_op(32'h8765_4321, 5'd7, 1'b1, lat, bc, ov);
        checks++; if (y !== 32'hFF0E_CA86) begin errors++; $display("FAIL sra7_y got %h want ff0eca86", y); end
        checks++; if (lat != exp_lat(7)) begin errors++; $display("FAIL sra7_lat got %0d want %0d", lat, exp_lat(7)); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_shift();
        int lat, bc, ov;
        run_op(32'hDEAD_BEEF, 5'd0, 1'b0, lat, bc, ov);
        checks++; if (y !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zero_y got %h want deadbeef", y); end
        checks++; if (bc != 1) begin errors++; $display("FAIL zero_busy_cycles got %0d want 1", bc); end
        checks++; if (lat != 1) begin errors++; $display("FAIL zero_lat got %0d want 1", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_start();
        int lat, dcnt;
        lat = -1; dcnt = 0;
        a = 32'h0000_FF00; shamt = 5'd8; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (n == 2) begin start = 1'b1; a = 32'h1234_5678; shamt = 5'd1; end
            if (n == 3) begin start = 1'b0; a = 32'h0; shamt = 5'd0; end
            if (done) begin
                dcnt++;
                if (lat < 0) begin
                    lat = n;
                    checks++; if (y !== 32'h0000_00FF) begin errors++; $display("FAIL ign_y got %h want 000000ff", y); end
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (lat != exp_lat(8)) begin errors++; $display("FAIL ign_lat got %0d want %0d", lat, exp_lat(8)); end
        checks++; if (dcnt != 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", dcnt); end
    endtask

    task automatic test_reset_mid();
        int dcnt, lat, bc, ov;
        dcnt = 0;
        a = 32'hFFFF_0000; shamt = 5'd20; arith = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b want 0", busy); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL rmid_y got %h want 00000000", y); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        checks++; if (dcnt != 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", dcnt); end
        run_op(32'h8000_0000, 5'd4, 1'b0, lat, bc, ov);
        checks++; if (y !== 32'h0800_0000) begin errors++; $display("FAIL rmid_next_y got %h want 08000000", y); end
        checks++; if (lat != exp_lat(4)) begin errors++; $display("FAIL rmid_next_lat got %0d want %0d", lat, exp_lat(4)); end
        @(posedge clk); #1;
        // Request waiting while reset releases is taken on the first edge after release.
        reset = 1'b1;
        a = 32'h0000_0F00; shamt = 5'd8; arith = 1'b0; start = 1'b1;
        #3;
        reset = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rrel_busy got %0b want 1", busy); end
        lat = -1;
        for (int n = 0; n < 60; n++) begin
            if (done) begin lat = n; break; end
            @(posedge clk); #1;
        end
        checks++; if (lat != exp_lat(8) || y !== 32'h0000_000F) begin
            errors++; $display("FAIL rrel_result got lat %0d y %h want lat %0d y 0000000f", lat, y, exp_lat(8));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bc, ov, held_bad;
        held_bad = 0;
        run_op(32'h0000_FF00, 5'd8, 1'b0, lat, bc, ov);
        checks++; if (y !== 32'h0000_00FF) begin errors++; $display("FAIL b2b_first_y got %h want 000000ff", y); end
        // Still in the done cycle: request the next operation.
        a = 32'hF000_0000; shamt = 5'd28; arith = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'h0; shamt = 5'd0; arith = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_next got %0b want 1", busy); end
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            if (done) begin lat = n; break; end
            if (y !== 32'h0000_00FF) held_bad++;
            @(posedge clk); #1;
        end
        checks++; if (held_bad != 0) begin errors++; $display("FAIL b2b_y_hold got %0d bad cycles want 0", held_bad); end
        checks++; if (y !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_second_y got %h want ffffffff", y); end
        checks++; if (lat != exp_lat(28)) begin errors++; $display("FAIL b2b_lat got %0d want %0d", lat, exp_lat(28)); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got done %0b busy %0b want 0 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_logical_long();
        test_arith();
        test_zero_shift();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
